// File: rtl/serial_word_tx.sv
// serial_word_tx: valid/ready parallel-to-serial transmitter, LSB first, with sof/eof markers
// and optional on-the-fly two's complement (copy up to and including the first one, then invert).
module serial_word_tx #(
    parameter int W   = 8,
    parameter int GAP = 1
) (
    input  logic         t_clk,
    input  logic         r,
    input  logic [W-1:0] in_data,
    input  logic         in_neg,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         ser_o,
    output logic         ser_vld,
    output logic         ser_sof,
    output logic         ser_eof,
    output logic         busy
);
    localparam int CW = $clog2(W);
    localparam int GW = GAP > 1 ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAPS} state_t;

    state_t        state;
    logic [W-1:0]  sr;
    logic          neg;
    logic          seen_one;
    logic [CW-1:0] cnt;
    logic [GW-1:0] gcnt;
    logic          b;

    assign in_ready = r & (state == IDLE);
    assign b        = sr[0];

    // Bit 0 is driven straight from in_data on acceptance, so sr holds the bits still to go
    // and seen_one already accounts for bit 0.
    always_ff @(posedge t_clk or negedge r) begin
        if (!r) begin
            state    <= IDLE;
            sr       <= '0;
            neg      <= 1'b0;
            seen_one <= 1'b0;
            cnt      <= '0;
            gcnt     <= '0;
            ser_o    <= 1'b0;
            ser_vld  <= 1'b0;
            ser_sof  <= 1'b0;
            ser_eof  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state    <= SHIFT;
                    sr       <= in_data >> 1;
                    neg      <= in_neg;
                    seen_one <= in_data[0];
                    cnt      <= '0;
                    ser_o    <= in_data[0];
                    ser_vld  <= 1'b1;
                    ser_sof  <= 1'b1;
                    ser_eof  <= 1'b0;
                    busy     <= 1'b1;
                end
                SHIFT: if (cnt == CW'(W - 1)) begin
                    ser_o   <= 1'b0;
                    ser_vld <= 1'b0;
                    ser_sof <= 1'b0;
                    ser_eof <= 1'b0;
                    gcnt    <= '0;
                    state   <= GAP > 0 ? GAPS : IDLE;
                    busy    <= GAP > 0;
                end else begin
                    ser_o    <= (neg & seen_one) ? ~b : b;
                    seen_one <= seen_one | b;
                    sr       <= sr >> 1;
                    cnt      <= cnt + 1'b1;
                    ser_sof  <= 1'b0;
                    ser_eof  <= cnt == CW'(W - 2);
                end
                GAPS: if (gcnt == GW'(GAP - 1)) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    gcnt <= gcnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_word_tx.sv
// tb_serial_word_tx: two instances (GAP=1 and GAP=0) checked every cycle against a word-position
// model, plus directed literal stream checks and randomized traffic.
module tb_serial_word_tx;
    localparam int W = 8;

    logic         t_clk = 1'b0;
    logic         r = 1'b0;
    logic [W-1:0] in_data[2];
    logic         in_neg[2], in_valid[2];
    logic         in_ready[2], ser_o[2], ser_vld[2], ser_sof[2], ser_eof[2], busy[2];

    always #5 t_clk = ~t_clk;

    serial_word_tx #(.W(W), .GAP(1)) dut_g1 (
        .t_clk(t_clk), .r(r), .in_data(in_data[0]), .in_neg(in_neg[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .ser_o(ser_o[0]), .ser_vld(ser_vld[0]), .ser_sof(ser_sof[0]),
        .ser_eof(ser_eof[0]), .busy(busy[0]));

    serial_word_tx #(.W(W), .GAP(0)) dut_g0 (
        .t_clk(t_clk), .r(r), .in_data(in_data[1]), .in_neg(in_neg[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .ser_o(ser_o[1]), .ser_vld(ser_vld[1]), .ser_sof(ser_sof[1]),
        .ser_eof(ser_eof[1]), .busy(busy[1]));

    function automatic int gap_of(int i);
        return i == 0 ? 1 : 0;
    endfunction

    // Model: pos is the slot of the word sequence shown this cycle (bits 0..W-1, then GAP
    // idle-but-busy slots); -1 means idle and ready.
    int           pos[2] = '{-1, -1};
    logic [W-1:0] v[2];

    always @(posedge t_clk or negedge r) begin
        for (int i = 0; i < 2; i++) begin
            if (!r) pos[i] = -1;
            else if (pos[i] < 0) begin
                if (in_valid[i]) begin
                    pos[i] = 0;
                    v[i] = in_neg[i] ? W'((1 << W) - int'(in_data[i])) : in_data[i];
                end
            end else pos[i] = (pos[i] + 1 == W + gap_of(i)) ? -1 : pos[i] + 1;
        end
    end

    int           n_cmp = 0, n_fail = 0, cyc = 0;
    string        nmq[$];
    logic [31:0]  actq[$], expq[$];
    int           idx[2] = '{0, 0}, word_cnt[2] = '{0, 0}, eof_cyc[2] = '{0, 0}, last_bubble[2] = '{0, 0};
    logic [W-1:0] cap[2], last_word[2];

    always @(negedge t_clk) begin
        logic [5:0] a, e;
        string nm;
        logic [31:0] qa, qe;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            a = {ser_o[i], ser_vld[i], ser_sof[i], ser_eof[i], busy[i], in_ready[i]};
            e = {pos[i] >= 0 && pos[i] < W ? v[i][pos[i]] : 1'b0,
                 pos[i] >= 0 && pos[i] < W, pos[i] == 0, pos[i] == W - 1, pos[i] >= 0,
                 r && pos[i] < 0};
            n_cmp++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL model[%0d] cyc %0d {o,vld,sof,eof,busy,rdy}: got %b want %b", i, cyc, a, e);
            end
            if (ser_vld[i]) begin
                if (ser_sof[i]) begin
                    idx[i] = 0;
                    last_bubble[i] = cyc - eof_cyc[i] - 1;
                end
                if (idx[i] < W) cap[i][idx[i]] = ser_o[i];
                idx[i]++;
                if (ser_eof[i]) begin
                    last_word[i] = cap[i];
                    word_cnt[i]++;
                    eof_cyc[i] = cyc;
                end
            end
        end
        while (nmq.size() > 0) begin
            nm = nmq.pop_front();
            qa = actq.pop_front();
            qe = expq.pop_front();
            n_cmp++;
            if (qa !== qe) begin
                n_fail++;
                $display("FAIL %s: got %0h want %0h", nm, qa, qe);
            end
        end
    end

    task automatic post(string nm, logic [31:0] a, logic [31:0] e);
        nmq.push_back(nm);
        actq.push_back(a);
        expq.push_back(e);
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge t_clk);
        #2;
    endtask

    task automatic wait_accept(int i);
        int  k;
        logic acc;
        k = 0;
        acc = 1'b0;
        while (!acc && k < 50) begin
            @(negedge t_clk);
            acc = in_ready[i];
            @(posedge t_clk);
            #2;
            k++;
        end
        if (!acc) post("timeout_accept", 0, 1);
    endtask

    task automatic send(int i, logic [W-1:0] d, logic ng);
        in_data[i] = d;
        in_neg[i] = ng;
        in_valid[i] = 1'b1;
        wait_accept(i);
        in_valid[i] = 1'b0;
    endtask

    task automatic wait_words(int i, int target, string nm);
        int k;
        k = 0;
        while (word_cnt[i] < target && k < 60) begin
            @(posedge t_clk);
            k++;
        end
        #2;
        if (word_cnt[i] < target) post({nm, "_timeout"}, 0, 1);
    endtask

    task automatic tx(int i, logic [W-1:0] d, logic ng, logic [W-1:0] e, string nm);
        int c0;
        c0 = word_cnt[i];
        send(i, d, ng);
        wait_words(i, c0 + 1, nm);
        post(nm, last_word[i], e);
    endtask

    task automatic b2b(int i, int bubble);
        int c0;
        c0 = word_cnt[i];
        in_data[i] = 8'hFF;
        in_neg[i] = 1'b0;
        in_valid[i] = 1'b1;
        wait_accept(i);
        in_data[i] = 8'h01;
        wait_accept(i);
        in_valid[i] = 1'b0;
        wait_words(i, c0 + 2, "b2b");
        post("b2b_word2", last_word[i], 8'h01);
        post("b2b_bubble", last_bubble[i], bubble);
    endtask

    initial begin
        int c0;
        for (int i = 0; i < 2; i++) begin
            in_data[i] = '0;
            in_neg[i] = 1'b0;
            in_valid[i] = 1'b0;
        end
        tick(3);
        post("reset_state", {ser_o[0], ser_vld[0], ser_sof[0], ser_eof[0], busy[0], in_ready[0]}, 0);
        r = 1'b1;
        #1 post("ready_after_reset", in_ready[0], 1);
        tick(2);

        tx(0, 8'h05, 1'b0, 8'h05, "word_05");
        tx(0, 8'h06, 1'b1, 8'hFA, "neg_06");
        tx(0, 8'h00, 1'b1, 8'h00, "neg_zero");
        tx(0, 8'h80, 1'b1, 8'h80, "neg_min");
        tx(1, 8'h6B, 1'b1, 8'h95, "neg_6b_g0");

        b2b(1, 1);
        b2b(0, 2);

        c0 = word_cnt[0];
        send(0, 8'h5A, 1'b0);
        tick(2);
        in_data[0] = 8'hFF;
        in_valid[0] = 1'b1;
        tick(1);
        in_valid[0] = 1'b0;
        wait_words(0, c0 + 1, "pulse_busy");
        post("pulse_busy_word", last_word[0], 8'h5A);
        tick(15);
        post("pulse_busy_count", word_cnt[0] - c0, 1);

        c0 = word_cnt[0];
        send(0, 8'hA5, 1'b0);
        tick(3);
        r = 1'b0;
        #1 post("rst_mid_outs", {ser_o[0], ser_vld[0], ser_sof[0], ser_eof[0], busy[0], in_ready[0]}, 0);
        @(negedge t_clk);
        #2 r = 1'b1;
        #1 post("rst_release_rdy", in_ready[0], 1);
        tick(12);
        post("rst_no_eof", word_cnt[0] - c0, 0);
        tx(0, 8'h3C, 1'b0, 8'h3C, "after_rst_3c");

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                in_valid[i] = $urandom_range(0, 2) == 0;
                in_data[i] = W'($urandom);
                in_neg[i] = 1'($urandom);
            end
            if (n == 200) begin
                r = 1'b0;
                @(negedge t_clk);
                #2 r = 1'b1;
            end
            tick(1);
        end
        for (int i = 0; i < 2; i++) in_valid[i] = 1'b0;
        tick(20);
        for (int k = 0; k < 10 && nmq.size() > 0; k++) @(posedge t_clk);
        @(posedge t_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
